dnn_accel_clk_enable_gen: RTL
=============================

# dnn_accel_clk_enable_gen

Multi-channel, runtime-programmable clock-enable generator. It is the fabric-side successor to the fixed-ratio PLL wrapper. From one system clock it derives NUM_CH phase-aligned single-cycle enable strobes and 50%-nominal square waves, each with its own divide ratio and phase offset, so accelerator sub-blocks run at divided rates without gated or derived clocks. A config port reprograms any channel at run time; `locked` reports when all channels have been re-aligned and have settled.

## Interface
- `NUM_CH`, 3: number of output channels (1..16)
- `DIV_W`, 8: width of divide/phase fields; max period 2^DIV_W cycles
- `DEFAULT_DIV`, 1: per-channel divide value after reset (period = DEFAULT_DIV+1)
- `LOCK_CYCLES`, 16: settle cycles after alignment before `locked` rises (>=1)
- `CH_W`, derived, max(1,$clog2(NUM_CH)): channel index width
- `refclk  in  1`  sole clock; all logic on rising edge
- `rst  in  1`  reset: synchronous, active-high
- `cfg_wr  in  1`  config write strobe, accepted when `cfg_ready`=1
- `cfg_ch  in  CH_W`  target channel index
- `cfg_div  in  DIV_W`  divide value d; channel period = d+1 cycles
- `cfg_phase  in  DIV_W`  strobe offset within period
- `cfg_ready  out  1`  write accepted this cycle if `cfg_wr`=1
- `ce  out  NUM_CH`  per-channel one-cycle enable strobe
- `sq  out  NUM_CH`  per-channel square wave
- `locked  out  1`  all channels aligned and settled

## Operation
- Per channel i: active regs `div[i]` and `ph[i]`, and counter `cnt[i]` in 0..div[i]. `cnt` increments each cycle and wraps to 0 after reaching div[i].
- `ph` is stored clamped: a written phase > div is stored as div.
- `ce[i]` = (cnt[i]==ph[i]) && state∈{SETTLE,LOCKED}. With d=0, `ce[i]` is constantly 1.
- `sq[i]` = (cnt[i] < (div[i]+2)>>1) && state∈{SETTLE,LOCKED}. It is high for ceil((d+1)/2) cycles. With d=0, `sq` is constantly 1.
- FSM states: RST, APPLY, SETTLE, LOCKED.
  - RST: entered on any edge with `rst`=1, from any state. On that edge all `cnt`=0, div=DEFAULT_DIV, ph=0, settle counter=0.
  - RST -> SETTLE on the first edge with `rst`=0. Counters stay 0 through that edge.
  - SETTLE: counters run and the settle counter increments. When the settle counter reaches LOCK_CYCLES, the FSM moves to LOCKED.
  - Accepted write (in SETTLE or LOCKED, `cfg_ch`<NUM_CH) -> APPLY. `cfg_div` and the clamped `cfg_phase` are captured into a shadow reg.
  - APPLY (exactly 1 cycle): on its closing edge the shadow is copied into active regs of `cfg_ch`, ALL `cnt`=0, settle counter=0, and the FSM moves to SETTLE. Other channels keep their div/ph but are re-aligned.
- `cfg_ready` = state∈{SETTLE,LOCKED}.
- A write with `cfg_ch`>=NUM_CH is consumed with no effect: no state change, and `locked` is unaffected.
- A write during SETTLE restarts alignment and the settle window.
- `cfg_wr` while `cfg_ready`=0 is ignored, with no buffering.
- `rst` wins over `cfg_wr` on the same edge.

## Timing
- Reset values, from the first edge with `rst`=1: `ce`=0, `sq`=0, `locked`=0, `cfg_ready`=0. All outputs are decoded from registers (state, cnt, div, ph), with no input-to-output combinational path.
- Reset release: `rst` falls before edge E0. In the cycle after E0, state=SETTLE, all cnt=0, and `ce` is asserted for channels with ph=0.
- `locked` rises exactly LOCK_CYCLES cycles after SETTLE entry and stays high until the next accepted write or `rst`.
- Config write accepted at edge k:
  - Cycle k+1: APPLY; `locked`=0, `cfg_ready`=0, `ce`=`sq`=0.
  - Cycle k+2: SETTLE with new settings, all cnt=0.
  - Cycle k+2+LOCK_CYCLES: `locked`=1.
- After alignment, channel i strobes at cycles t0 + ph[i] + n·(div[i]+1), where t0 = the first SETTLE cycle.

## Test plan
- Reset, defaults (NUM_CH=3, DEFAULT_DIV=1, LOCK_CYCLES=16):
  - During `rst` all outputs are 0.
  - After release, `ce`=3'b111 on alternate cycles starting at the first cycle.
  - `sq` toggles 1,0,1,0.
  - `locked` rises 16 cycles after release.
- Reprogram one channel: write ch1 div=4 phase=2.
  - `locked` drops the next cycle; `cfg_ready`=0 for 1 cycle.
  - Then ce[1] fires at t0+2, t0+7, t0+12.
  - sq[1] pattern is 1,1,1,0,0 repeating.
  - ch0 and ch2 restart at cnt=0.
  - `locked` re-rises at t0+16.
- Boundary values:
  - div=0 on ch2 gives ce[2]=sq[2]=1 every SETTLE/LOCKED cycle.
  - div=255, phase=255: ce fires once per 256 cycles at cnt=255, and sq is high for 128 cycles.
  - div=3, phase=9: phase is clamped, so ce fires at cnt=3.
- Invalid and blocked writes:
  - `cfg_ch`=3 with NUM_CH=3: `locked` stays 1 and no channel changes.
  - `cfg_wr` during APPLY is ignored.
- Write during SETTLE (8 cycles in): settle restarts, and `locked` rises 16 cycles after the new SETTLE entry, not earlier.
- `rst` asserted the same edge as an accepted write, and mid-LOCKED:
  - All channels return to defaults.
  - The previous write is discarded.
  - `locked`=0 the next cycle.

Source files
------------

// File: rtl/dnn_accel_clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divided strobes and
// square waves from one clock, re-aligned on every reconfiguration, with a lock indicator.
module dnn_accel_clk_enable_gen #(
  parameter int NUM_CH      = 3,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam int SET_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_RST, S_APPLY, S_SETTLE, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [DIV_W-1:0] cnt_q [NUM_CH];
  logic [DIV_W-1:0] cnt_d [NUM_CH];
  logic [DIV_W-1:0] div_q [NUM_CH];
  logic [DIV_W-1:0] div_d [NUM_CH];
  logic [DIV_W-1:0] ph_q  [NUM_CH];
  logic [DIV_W-1:0] ph_d  [NUM_CH];
  logic [CH_W-1:0]  sh_ch_q, sh_ch_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic [DIV_W-1:0] sh_ph_q, sh_ph_d;
  logic             run;
  logic             wr_acc;

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] ph,
                                                   input logic [DIV_W-1:0] div);
    return (ph > div) ? div : ph;
  endfunction

  function automatic logic [DIV_W:0] sq_high_len(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] sum;
    sum = {1'b0, div} + (DIV_W+1)'(2);
    return sum >> 1;
  endfunction

  assign run       = (state_q == S_SETTLE) || (state_q == S_LOCKED);
  assign cfg_ready = run;
  assign locked    = (state_q == S_LOCKED);
  // Out-of-range channel writes are swallowed here and never reach the FSM.
  assign wr_acc    = run && cfg_wr && (32'(cfg_ch) < 32'(NUM_CH));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ce[i] = run && (cnt_q[i] == ph_q[i]);
      sq[i] = run && ({1'b0, cnt_q[i]} < sq_high_len(div_q[i]));
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    ph_d     = ph_q;
    sh_ch_d  = sh_ch_q;
    sh_div_d = sh_div_q;
    sh_ph_d  = sh_ph_q;

    if (run) begin
      for (int i = 0; i < NUM_CH; i++)
        cnt_d[i] = (cnt_q[i] == div_q[i]) ? '0 : cnt_q[i] + 1'b1;
    end

    case (state_q)
      S_RST:    state_d = S_SETTLE;
      S_APPLY: begin
        for (int i = 0; i < NUM_CH; i++) begin
          cnt_d[i] = '0;
          if (32'(sh_ch_q) == 32'(i)) begin
            div_d[i] = sh_div_q;
            ph_d[i]  = sh_ph_q;
          end
        end
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = settle_q + 1'b1;
        if (settle_q == SET_W'(LOCK_CYCLES - 1))
          state_d = S_LOCKED;
      end
      default: ;
    endcase

    if (wr_acc) begin
      state_d  = S_APPLY;
      sh_ch_d  = cfg_ch;
      sh_div_d = cfg_div;
      sh_ph_d  = clamp_phase(cfg_phase, cfg_div);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= S_RST;
      settle_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_W'(DEFAULT_DIV);
        ph_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
    end
  end

  // Shadow holds data only; it is always rewritten before APPLY consumes it.
  always_ff @(posedge refclk) begin
    sh_ch_q  <= sh_ch_d;
    sh_div_q <= sh_div_d;
    sh_ph_q  <= sh_ph_d;
  end

endmodule
